// File: rtl/avs_csr_responder.sv
// avs_csr_responder: Avalon-MM CSR slave with ID, scratch, control/status, soft IRQ and optional countdown timer.
// Define AVS_CSR_TIMER_EN to compile in the timer (TIMER_LOAD/TIMER_COUNT, CONTROL[2:1], STATUS[0]).
module avs_csr_responder #(
    parameter logic [15:0] ID_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_csr_address,
    input  logic        avs_csr_write,
    input  logic [31:0] avs_csr_writedata,
    input  logic        avs_csr_read,
    output logic [31:0] avs_csr_readdata,
    output logic        avs_csr_readdatavalid,
    output logic        irq
);
    logic [31:0] r_scratch0;
    logic [31:0] r_scratch1;
    logic [2:0]  r_ctrl;
    logic [1:0]  r_status;
    logic [31:0] r_readdata;
    logic        r_readdatavalid;
    logic        r_irq;
    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic        w_expire;
    logic [2:0]  w_ctrl_mask;
    logic [1:0]  w_status_next;
`ifdef AVS_CSR_TIMER_EN
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_reload;
    logic        w_wr_load;
`endif

    always_comb begin
        w_hit = avs_csr_address[31:3] == 29'd0;
        w_idx = avs_csr_address[2:0];
        w_wr  = avs_csr_write & w_hit;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd0:    w_rdata = {16'hA5A5, ID_VALUE};
            3'd1:    w_rdata = r_scratch0;
            3'd2:    w_rdata = r_scratch1;
            3'd3:    w_rdata = {29'd0, r_ctrl};
            3'd4:    w_rdata = {30'd0, r_status};
`ifdef AVS_CSR_TIMER_EN
            3'd6:    w_rdata = r_load;
            3'd7:    w_rdata = r_count;
`endif
            default: w_rdata = 32'd0;
        endcase
        if (!w_hit) w_rdata = 32'd0;
    end

`ifdef AVS_CSR_TIMER_EN
    // A TIMER_LOAD write overrides the decrement, so it also suppresses the expiry.
    always_comb begin
        w_wr_load   = w_wr && w_idx == 3'd6;
        w_expire    = r_ctrl[1] && r_count == 32'd1 && !w_wr_load;
        w_ctrl_mask = 3'b111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load   <= 32'd0;
            r_count  <= 32'd0;
            r_reload <= 1'b0;
        end else begin
            r_reload <= w_expire & r_ctrl[2];
            if (w_wr_load) begin
                r_load  <= avs_csr_writedata;
                r_count <= avs_csr_writedata;
            end else if (r_reload) begin
                r_count <= r_load;
            end else if (r_ctrl[1] && r_count != 32'd0) begin
                r_count <= r_count - 32'd1;
            end
        end
    end
`else
    always_comb begin
        w_expire    = 1'b0;
        w_ctrl_mask = 3'b001;
    end
`endif

    // Set events are OR'd in after the W1C mask so a simultaneous set wins.
    always_comb begin
        w_status_next = r_status & ~((w_wr && w_idx == 3'd4) ? avs_csr_writedata[1:0] : 2'b00);
        w_status_next = w_status_next | {w_wr && w_idx == 3'd5 && avs_csr_writedata[0], w_expire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch0      <= 32'd0;
            r_scratch1      <= 32'd0;
            r_ctrl          <= 3'd0;
            r_status        <= 2'd0;
            r_readdata      <= 32'd0;
            r_readdatavalid <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            if (w_wr && w_idx == 3'd1) r_scratch0 <= avs_csr_writedata;
            if (w_wr && w_idx == 3'd2) r_scratch1 <= avs_csr_writedata;
            if (w_wr && w_idx == 3'd3) r_ctrl <= avs_csr_writedata[2:0] & w_ctrl_mask;
            r_status        <= w_status_next;
            r_irq           <= r_ctrl[0] & (|r_status);
            r_readdatavalid <= avs_csr_read;
            if (avs_csr_read) r_readdata <= w_rdata;
        end
    end

    assign avs_csr_readdata      = r_readdata;
    assign avs_csr_readdatavalid = r_readdatavalid;
    assign irq                   = r_irq;
endmodule

// File: tb/tb_avs_csr_responder.sv
// tb_avs_csr_responder: directed and random checks of avs_csr_responder against a register-map model.
module tb_avs_csr_responder;
    localparam logic [15:0] ID = 16'h0012;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = 32'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;
    int errors = 0;
    int checks = 0;
    logic [31:0] m_sc0, m_sc1, m_load, m_count, m_rdata;
    logic [2:0]  m_ctrl;
    logic [1:0]  m_status;
    logic        m_pend, m_irq, m_rv;

    avs_csr_responder #(.ID_VALUE(ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .avs_csr_address(address), .avs_csr_write(write), .avs_csr_writedata(writedata),
        .avs_csr_read(read), .avs_csr_readdata(readdata),
        .avs_csr_readdatavalid(readdatavalid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_sc0 = 0; m_sc1 = 0; m_load = 0; m_count = 0; m_rdata = 0;
        m_ctrl = 0; m_status = 0; m_pend = 0; m_irq = 0; m_rv = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a > 32'd7) return 32'd0;
        if (a == 0) return {16'hA5A5, ID};
        if (a == 1) return m_sc0;
        if (a == 2) return m_sc1;
        if (a == 3) return {29'd0, m_ctrl};
        if (a == 4) return {30'd0, m_status};
`ifdef AVS_CSR_TIMER_EN
        if (a == 6) return m_load;
        if (a == 7) return m_count;
`endif
        return 32'd0;
    endfunction

    // One bus cycle: drive at negedge, advance the model by one clock, compare after the edge.
    task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rval;
        logic irq_n;
        bit expire;
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = d;
        rval = m_read(a);
        @(posedge clk);
        #1;
        irq_n = m_ctrl[0] & (|m_status);
        expire = 0;
`ifdef AVS_CSR_TIMER_EN
        expire = m_ctrl[1] && m_count == 1 && !(wr && a == 6);
        if (wr && a == 6) begin
            m_load = d;
            m_count = d;
        end else if (m_pend) m_count = m_load;
        else if (m_ctrl[1] && m_count != 0) m_count = m_count - 1;
        m_pend = expire & m_ctrl[2];
`endif
        if (wr && a == 4) m_status = m_status & ~d[1:0];
        if (wr && a == 5 && d[0]) m_status[1] = 1'b1;
        if (expire) m_status[0] = 1'b1;
        if (wr && a == 1) m_sc0 = d;
        if (wr && a == 2) m_sc1 = d;
`ifdef AVS_CSR_TIMER_EN
        if (wr && a == 3) m_ctrl = d[2:0];
`else
        if (wr && a == 3) m_ctrl = {2'b00, d[0]};
`endif
        m_irq = irq_n;
        m_rv = rd;
        if (rd) m_rdata = rval;
        chk("rvalid", {31'd0, readdatavalid}, {31'd0, m_rv});
        chk("rdata", readdata, m_rdata);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a, d;
        m_reset();
        #1;
        chk("reset_rvalid", {31'd0, readdatavalid}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        chk("id_read", readdata, 32'hA5A50012);
        idle(1);
        step(0, 1, 1, 32'hCAFEF00D);
        step(1, 0, 1, 0);
        chk("scratch0_rdbk", readdata, 32'hCAFEF00D);
        step(1, 0, 9, 0);
        chk("oob_data", readdata, 32'd0);
        chk("oob_valid", {31'd0, readdatavalid}, 32'd1);
        step(0, 1, 2, 32'h12345678);
        step(1, 0, 1, 0);
        chk("b2b_0", readdata, 32'hCAFEF00D);
        step(1, 0, 2, 0);
        chk("b2b_1", readdata, 32'h12345678);
        step(1, 1, 0, 0);
        chk("b2b_2", readdata, 32'hA5A50012);
        step(1, 1, 1, 32'h0BADBEEF);
        chk("rw_same_cycle", readdata, 32'hCAFEF00D);
        step(1, 0, 1, 0);
        chk("rw_after", readdata, 32'h0BADBEEF);
        step(0, 1, 5, 1);
        step(1, 0, 4, 0);
        chk("softirq_status", readdata, 32'd2);
        chk("softirq_noirq", {31'd0, irq}, 32'd0);
        step(1, 0, 5, 0);
        chk("softirq_rd0", readdata, 32'd0);
        step(0, 1, 3, 1);
        idle(1);
        chk("softirq_irq", {31'd0, irq}, 32'd1);
        step(0, 1, 4, 2);
        idle(1);
        chk("w1c_irq_low", {31'd0, irq}, 32'd0);
`ifdef AVS_CSR_TIMER_EN
        step(0, 1, 3, 3);
        step(0, 1, 6, 5);
        idle(4);
        step(1, 0, 4, 0);
        chk("tmr_not_yet", readdata, 32'd0);
        step(1, 0, 4, 0);
        chk("tmr_expired", readdata, 32'd1);
        chk("tmr_irq", {31'd0, irq}, 32'd1);
        step(1, 0, 7, 0);
        chk("tmr_hold0", readdata, 32'd0);
        step(0, 1, 4, 1);
        idle(1);
        chk("tmr_irq_clr", {31'd0, irq}, 32'd0);
        step(0, 1, 3, 7);
        step(0, 1, 6, 3);
        idle(2);
        step(0, 1, 4, 1);
        step(1, 0, 4, 0);
        chk("set_wins", readdata, 32'd1);
        step(1, 0, 7, 0);
        chk("auto_reload", readdata, 32'd3);
        step(0, 1, 3, 0);
        step(0, 1, 4, 3);
`else
        step(0, 1, 6, 32'h55);
        step(1, 0, 6, 0);
        chk("no_tmr_load", readdata, 32'd0);
        step(1, 0, 7, 0);
        chk("no_tmr_count", readdata, 32'd0);
        step(0, 1, 3, 7);
        step(1, 0, 3, 0);
        chk("no_tmr_ctrl", readdata, 32'd1);
`endif
        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d = $urandom;
            if (a == 6) d = $urandom_range(0, 6);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, d);
        end
        step(0, 1, 1, 32'h11111111);
        step(0, 1, 3, 3);
        @(negedge clk);
        read = 1; write = 0; address = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        read = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        for (int i = 1; i < 8; i++) begin
            step(1, 0, i, 0);
            chk("rst_regs", readdata, 32'd0);
        end
        idle(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avs_csr_responder.md
AVS_CSR_RESPONDER -- requirements
Module: avs_csr_responder

Interface
REQ-001 SHALL have parameter ID_VALUE, default 16'h0000, low half of the ID register.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port avs_csr_address  input  32  word address.
REQ-005 SHALL have port avs_csr_write  input  1  write strobe, single cycle per word.
REQ-006 SHALL have port avs_csr_writedata  input  32  write data.
REQ-007 SHALL have port avs_csr_read  input  1  read strobe, one-cycle pulse per request.
REQ-008 SHALL have port avs_csr_readdata  output  32  registered read data.
REQ-009 SHALL have port avs_csr_readdatavalid  output  1  read data qualifier.
REQ-010 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-011 SHALL decode word addresses 0-7; any address >= 8 SHALL read 32'h0 with normal valid timing, and writes to it SHALL be ignored.
REQ-012 SHALL implement map: 0 ID RO = {16'hA5A5, ID_VALUE}; 1 SCRATCH0 RW; 2 SCRATCH1 RW; 3 CONTROL RW bits[2:0] (0 irq_en, 1 timer_en, 2 auto_reload), others read 0; 4 STATUS bits[1:0] (0 timer_expired, 1 soft_irq), write-1-to-clear; 5 SOFTIRQ WO, write with bit0=1 sets STATUS[1], reads 0; 6 TIMER_LOAD RW; 7 TIMER_COUNT RO.
REQ-013 SHALL accept a read every cycle with no wait states; readdata and readdatavalid SHALL both be asserted exactly one cycle after avs_csr_read, for exactly one cycle per read.
REQ-014 readdata SHALL hold its last value while readdatavalid is low.
REQ-015 Read and write in the same cycle: both SHALL take effect; read SHALL return the pre-write value.
REQ-016 Writes SHALL update the target register on the edge they are sampled; the effect SHALL be visible to a read issued the next cycle.
REQ-017 Timer: while CONTROL[1]=1 and TIMER_COUNT!=0, TIMER_COUNT SHALL decrement by 1 per clock.
REQ-018 On the 1->0 transition of TIMER_COUNT, STATUS[0] SHALL set; if CONTROL[2]=1, TIMER_COUNT SHALL load TIMER_LOAD on the following cycle; otherwise it SHALL hold at 0.
REQ-019 A write to TIMER_LOAD SHALL also load TIMER_COUNT with the written value, overriding decrement in that cycle.
REQ-020 Simultaneous STATUS set event and W1C clear of the same bit: set SHALL win.
REQ-021 irq SHALL be registered: irq(next) = CONTROL[0] & (STATUS[0] | STATUS[1]); one cycle latency from the STATUS/CONTROL change.

Reset
REQ-022 On rst_n low, asynchronously: readdata=0, readdatavalid=0, irq=0, SCRATCH0/1=0, CONTROL=0, STATUS=0, TIMER_LOAD=0, TIMER_COUNT=0.
REQ-023 A read in flight when reset asserts SHALL be discarded; no readdatavalid SHALL follow reset release.

Configuration
REQ-024 Macro AVS_CSR_TIMER_EN: when defined, the timer (REQ-017..019) SHALL be compiled in.
REQ-025 Without AVS_CSR_TIMER_EN: addresses 6 and 7 SHALL read 0 and ignore writes, CONTROL[2:1] SHALL read 0, STATUS[0] SHALL remain 0; all other behaviour unchanged.

Verification
REQ-026 Reset, then read addr 0 with ID_VALUE=16'h0012 -> readdatavalid one cycle later, readdata=32'hA5A50012.
REQ-027 Write 32'hCAFEF00D to addr 1, read addr 1 next cycle -> 32'hCAFEF00D; read addr 9 -> 32'h0, valid still asserted.
REQ-028 Back-to-back reads addr 1,2,0 on consecutive cycles -> three consecutive valid cycles, data in order.
REQ-029 (timer on) CONTROL=3'b011, TIMER_LOAD=5 -> STATUS[0] sets 5 cycles after load, irq high one cycle after; write STATUS=1 -> irq low one cycle after clear.
REQ-030 Write SOFTIRQ=1 with CONTROL[0]=0 -> STATUS=2, irq stays 0; set CONTROL[0]=1 -> irq 1; W1C on the same cycle as a timer expiry -> STATUS[0] remains 1.
REQ-031 Assert rst_n low on the cycle after a read strobe -> no readdatavalid after release, all registers read 0.
